// File: rtl/noc_pkg.sv
// Shared types and header field layout for the OpenPiton-style 64-bit NoC flit path.
package noc_pkg;

    localparam int unsigned FLIT_W = 64;
    localparam int unsigned LEN_HI = 29;
    localparam int unsigned LEN_LO = 22;
    localparam int unsigned LEN_W  = LEN_HI - LEN_LO + 1;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {W_HEAD, W_BODY} wr_state_t;
    typedef enum logic {R_HEAD, R_BODY} rd_state_t;

    // Body-flit count carried in a header flit.
    function automatic logic [LEN_W-1:0] hdr_len(input flit_t f);
        return f[LEN_HI:LEN_LO];
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Single-clock flit FIFO with wrap-bit pointers; head is read straight from the registered array.
module noc_flit_fifo
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  flit_t wdata,
    output flit_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    flit_t         mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    always_comb begin
        full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        empty = (wr_ptr == rd_ptr);
        rdata = mem[rd_ptr[AW-1:0]];
    end

    // Array is cleared on reset so the head reads zero and no stale flit survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/noc_flit_injector.sv
// Packet-buffered val/yum flit transmitter; oversize packets are cut through.
// Optional trace prints under NOC_FLIT_INJECTOR_TRACE_EN.
module noc_flit_injector
    import noc_pkg::*;
#(
    parameter string       ID    = "inj",
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_val,
    input  logic [63:0] wr_data,
    output logic        wr_rdy,
    output logic [63:0] dout_msg,
    output logic        dout_val,
    input  logic        dout_yum,
    output logic [15:0] pkt_cnt,
    output logic        err_oversize,
    output logic        busy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wr_state_t        wr_st;
    rd_state_t        rd_st;
    logic [LEN_W-1:0] wr_rem;
    logic [LEN_W-1:0] rd_rem;
    logic [LEN_W-1:0] wr_len;
    logic [LEN_W-1:0] rd_len;
    logic [CW-1:0]    cmpl_cnt;
    logic             wr_ovs;
    logic             rd_ct;
    logic             ct_pending;
    logic             full;
    logic             empty;
    logic             wr_fire;
    logic             rd_fire;
    logic             ovs_hdr;
    logic             ct_hdr;
    logic             wr_done;
    logic             rd_last;
    logic             cmpl_inc;
    logic             cmpl_dec;

    noc_flit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_fire),
        .pop   (rd_fire),
        .wdata (wr_data),
        .rdata (dout_msg),
        .full  (full),
        .empty (empty)
    );

    // Packet-boundary decode; a header only launches once its packet is buffered or cut-through is granted.
    always_comb begin
        wr_rdy   = !full;
        wr_fire  = wr_val && !full;
        wr_len   = hdr_len(wr_data);
        rd_len   = hdr_len(dout_msg);
        dout_val = !empty && ((rd_st == R_BODY) || (cmpl_cnt != '0) || ct_pending);
        rd_fire  = dout_val && dout_yum;
        ovs_hdr  = wr_fire && (wr_st == W_HEAD) && (32'(wr_len) > DEPTH - 1);
        wr_done  = wr_fire && ((wr_st == W_HEAD) ? (wr_len == '0) : (wr_rem == LEN_W'(1)));
        cmpl_inc = wr_done && !((wr_st == W_BODY) && wr_ovs);
        ct_hdr   = rd_fire && (rd_st == R_HEAD) && ct_pending && (cmpl_cnt == '0);
        rd_last  = rd_fire && ((rd_st == R_HEAD) ? (rd_len == '0) : (rd_rem == LEN_W'(1)));
        cmpl_dec = rd_last && !((rd_st == R_BODY) && rd_ct);
        busy     = !empty || (rd_st == R_BODY);
    end

    // Write-side packet tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_st        <= W_HEAD;
            wr_rem       <= '0;
            wr_ovs       <= 1'b0;
            err_oversize <= 1'b0;
        end else begin
            if (wr_fire) begin
                case (wr_st)
                    W_HEAD: begin
                        if (wr_len != '0) begin
                            wr_st  <= W_BODY;
                            wr_rem <= wr_len;
                            wr_ovs <= ovs_hdr;
                        end
                    end
                    W_BODY: begin
                        wr_rem <= wr_rem - LEN_W'(1);
                        if (wr_rem == LEN_W'(1)) begin
                            wr_st <= W_HEAD;
                        end
                    end
                    default: wr_st <= W_HEAD;
                endcase
            end
            if (ovs_hdr) begin
                err_oversize <= 1'b1;
            end
        end
    end

    // Read-side packet tracker and delivered-packet counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_st   <= R_HEAD;
            rd_rem  <= '0;
            rd_ct   <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            if (rd_fire) begin
                case (rd_st)
                    R_HEAD: begin
                        rd_ct <= ct_hdr;
                        if (rd_len != '0) begin
                            rd_st  <= R_BODY;
                            rd_rem <= rd_len;
                        end
                    end
                    R_BODY: begin
                        rd_rem <= rd_rem - LEN_W'(1);
                        if (rd_rem == LEN_W'(1)) begin
                            rd_st <= R_HEAD;
                        end
                    end
                    default: rd_st <= R_HEAD;
                endcase
            end
            if (rd_last) begin
                pkt_cnt <= pkt_cnt + 16'(1);
            end
        end
    end

    // Buffered-packet count and the cut-through grant shared by both sides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmpl_cnt   <= '0;
            ct_pending <= 1'b0;
        end else begin
            case ({cmpl_inc, cmpl_dec})
                2'b10:   cmpl_cnt <= cmpl_cnt + CW'(1);
                2'b01:   cmpl_cnt <= cmpl_cnt - CW'(1);
                default: cmpl_cnt <= cmpl_cnt;
            endcase
            if (ct_hdr) begin
                ct_pending <= 1'b0;
            end
            if (ovs_hdr) begin
                ct_pending <= 1'b1;
            end
        end
    end

`ifdef NOC_FLIT_INJECTOR_TRACE_EN
    always_ff @(posedge clk) begin
        if (rd_fire) begin
            $display("(%s): INJ flit %h", ID, dout_msg);
        end
        if (ovs_hdr && !err_oversize) begin
            $display("(%s): INJ warning: oversize header %h", ID, wr_data);
        end
    end
`endif

endmodule

// File: tb/tb_noc_flit_injector.sv
// Randomized bench for noc_flit_injector against a packet-level queue model.
module tb_noc_flit_injector;
    import noc_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_val;
    logic [63:0] wr_data;
    logic        wr_rdy;
    logic [63:0] dout_msg;
    logic        dout_val;
    logic        dout_yum;
    logic [15:0] pkt_cnt;
    logic        err_oversize;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    noc_flit_injector #(.ID("inj"), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_val       (wr_val),
        .wr_data      (wr_data),
        .wr_rdy       (wr_rdy),
        .dout_msg     (dout_msg),
        .dout_val     (dout_val),
        .dout_yum     (dout_yum),
        .pkt_cnt      (pkt_cnt),
        .err_oversize (err_oversize),
        .busy         (busy)
    );

    // Model: buffered flits tagged by packet; a packet may launch once fully written or if oversize.
    flit_t mq[$];
    int    mpid[$];
    bit    pkt_done[256];
    bit    pkt_ovs[256];
    int    next_pid, w_pid, w_rem, r_rem, pkts_sent;
    bit    ovs_seen;
    flit_t stream[$];

    function automatic int flen(input flit_t f);
        return int'(f[LEN_HI:LEN_LO]);
    endfunction

    function automatic flit_t mk_hdr(input int len);
        flit_t f;
        f = {$urandom, $urandom};
        f[LEN_HI:LEN_LO] = 8'(len);
        return f;
    endfunction

    function automatic flit_t mk_body();
        flit_t f;
        f = {$urandom, $urandom};
        return f;
    endfunction

    function automatic bit m_val();
        if (mq.size() == 0) return 1'b0;
        if (r_rem > 0) return 1'b1;
        return pkt_done[mpid[0]] || pkt_ovs[mpid[0]];
    endfunction

    function automatic bit m_busy();
        return (mq.size() > 0) || (r_rem > 0);
    endfunction

    task automatic m_reset();
        mq.delete();
        mpid.delete();
        stream.delete();
        next_pid = 0; w_pid = 0; w_rem = 0; r_rem = 0; pkts_sent = 0; ovs_seen = 1'b0;
        for (int i = 0; i < 256; i++) begin
            pkt_done[i] = 1'b0;
            pkt_ovs[i]  = 1'b0;
        end
    endtask

    // One clock: drive at negedge, advance model across posedge, return at next negedge.
    task automatic step(input logic wv, input flit_t wd, input logic yum);
        bit    wf, rf;
        int    len;
        flit_t f;
        wr_val   = wv;
        wr_data  = wd;
        dout_yum = yum;
        wf = wv && (mq.size() < int'(DEPTH));
        rf = yum && m_val();
        @(posedge clk);
        if (rf) begin
            f = mq.pop_front();
            void'(mpid.pop_front());
            if (r_rem == 0) begin
                if (flen(f) == 0) pkts_sent++;
                else r_rem = flen(f);
            end else begin
                r_rem--;
                if (r_rem == 0) pkts_sent++;
            end
        end
        if (wf) begin
            if (w_rem == 0) begin
                len   = flen(wd);
                w_pid = next_pid % 256;
                next_pid++;
                pkt_ovs[w_pid]  = (len > int'(DEPTH) - 1);
                pkt_done[w_pid] = (len == 0);
                ovs_seen        = ovs_seen || pkt_ovs[w_pid];
                w_rem           = len;
            end else begin
                w_rem--;
                if (w_rem == 0) pkt_done[w_pid] = 1'b1;
            end
            mq.push_back(wd);
            mpid.push_back(w_pid);
        end
        @(negedge clk);
        wr_val   = 1'b0;
        dout_yum = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_wr_rdy: got %b want 1", wr_rdy); end
        n_checks++; if (dout_val !== 1'b0) begin n_fail++; $display("FAIL reset_dout_val: got %b want 0", dout_val); end
        n_checks++; if (dout_msg !== 64'h0) begin n_fail++; $display("FAIL reset_dout_msg: got %h want 0", dout_msg); end
        n_checks++; if (pkt_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
        n_checks++; if (err_oversize !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_oversize); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        flit_t h;
        h = mk_hdr(2);
        step(1'b1, h, 1'b1);
        n_checks++; if (dout_val !== 1'b0) begin n_fail++; $display("FAIL basic_early1: dout_val %b want 0", dout_val); end
        step(1'b1, mk_body(), 1'b1);
        n_checks++; if (dout_val !== 1'b0) begin n_fail++; $display("FAIL basic_early2: dout_val %b want 0", dout_val); end
        step(1'b1, mk_body(), 1'b1);
        n_checks++; if (dout_msg !== h) begin n_fail++; $display("FAIL basic_head: got %h want %h", dout_msg, h); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (dout_val !== 1'b1 || dout_msg !== mq[0]) begin
                n_fail++; $display("FAIL basic_xfer%0d: val %b msg %h want 1 %h", i, dout_val, dout_msg, mq[0]);
            end
            step(1'b0, '0, 1'b1);
        end
        n_checks++; if (dout_val !== 1'b0) begin n_fail++; $display("FAIL basic_end_val: got %b want 0", dout_val); end
        n_checks++; if (pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_pkt_cnt: got %0d want 1", pkt_cnt); end
    endtask

    task automatic test_stall();
        step(1'b1, mk_hdr(3), 1'b1);
        step(1'b1, mk_body(), 1'b1);
        step(1'b1, mk_body(), 1'b1);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (dout_val !== 1'b0) begin n_fail++; $display("FAIL stall_val%0d: got %b want 0", i, dout_val); end
            step(1'b0, '0, 1'b1);
        end
        step(1'b1, mk_body(), 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (dout_val !== 1'b1 || dout_msg !== mq[0]) begin
                n_fail++; $display("FAIL stall_xfer%0d: val %b msg %h want 1 %h", i, dout_val, dout_msg, mq[0]);
            end
            step(1'b0, '0, 1'b1);
        end
        n_checks++; if (dout_val !== 1'b0 || pkt_cnt !== 16'd2) begin
            n_fail++; $display("FAIL stall_end: val %b pkt_cnt %0d want 0 2", dout_val, pkt_cnt);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) step(1'b1, mk_hdr(0), 1'b0);
        n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL full_wr_rdy: got %b want 0", wr_rdy); end
        step(1'b1, mk_hdr(0), 1'b0);
        n_checks++; if (wr_rdy !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL full_hold: wr_rdy %b busy %b want 0 1", wr_rdy, busy);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (dout_val !== 1'b1 || dout_msg !== mq[0]) begin
                n_fail++; $display("FAIL full_drain%0d: val %b msg %h want 1 %h", i, dout_val, dout_msg, mq[0]);
            end
            step(1'b0, '0, 1'b1);
        end
        n_checks++; if (dout_val !== 1'b0 || wr_rdy !== 1'b1 || pkt_cnt !== 16'd18) begin
            n_fail++; $display("FAIL full_end: val %b rdy %b pkt_cnt %0d want 0 1 18", dout_val, wr_rdy, pkt_cnt);
        end
    endtask

    task automatic test_oversize();
        flit_t h;
        h = mk_hdr(20);
        step(1'b1, h, 1'b1);
        n_checks++; if (err_oversize !== 1'b1) begin n_fail++; $display("FAIL ovs_err: got %b want 1", err_oversize); end
        n_checks++; if (dout_val !== 1'b1 || dout_msg !== h) begin
            n_fail++; $display("FAIL ovs_cut: val %b msg %h want 1 %h", dout_val, dout_msg, h);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, mk_body(), 1'b1);
            n_checks++; if (dout_val !== m_val() || (m_val() && dout_msg !== mq[0])) begin
                n_fail++; $display("FAIL ovs_body%0d: val %b msg %h want %b", i, dout_val, dout_msg, m_val());
            end
        end
        for (int i = 0; i < 8 && mq.size() > 0; i++) begin
            n_checks++; if (dout_val !== 1'b1 || dout_msg !== mq[0]) begin
                n_fail++; $display("FAIL ovs_drain%0d: val %b msg %h want 1 %h", i, dout_val, dout_msg, mq[0]);
            end
            step(1'b0, '0, 1'b1);
        end
        n_checks++; if (pkt_cnt !== 16'd19 || busy !== 1'b0 || mq.size() != 0) begin
            n_fail++; $display("FAIL ovs_end: pkt_cnt %0d busy %b want 19 0", pkt_cnt, busy);
        end
    endtask

    task automatic test_simul();
        flit_t a, b, bb, c;
        a = mk_hdr(1); b = mk_hdr(1); bb = mk_body(); c = mk_hdr(1);
        step(1'b1, a, 1'b0);
        step(1'b1, mk_body(), 1'b0);
        step(1'b1, b, 1'b1);
        step(1'b1, bb, 1'b1);
        n_checks++; if (dout_val !== 1'b1 || dout_msg !== b) begin
            n_fail++; $display("FAIL simul_b_launch: val %b msg %h want 1 %h", dout_val, dout_msg, b);
        end
        step(1'b1, c, 1'b1);
        n_checks++; if (dout_val !== 1'b1 || dout_msg !== bb) begin
            n_fail++; $display("FAIL simul_b_body: val %b msg %h want 1 %h", dout_val, dout_msg, bb);
        end
        step(1'b0, '0, 1'b1);
        n_checks++; if (dout_val !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL simul_c_hold: val %b busy %b want 0 1", dout_val, busy);
        end
        step(1'b1, mk_body(), 1'b1);
        n_checks++; if (dout_val !== 1'b1 || dout_msg !== c) begin
            n_fail++; $display("FAIL simul_c_launch: val %b msg %h want 1 %h", dout_val, dout_msg, c);
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        n_checks++; if (dout_val !== 1'b0 || pkt_cnt !== 16'd22) begin
            n_fail++; $display("FAIL simul_end: val %b pkt_cnt %0d want 0 22", dout_val, pkt_cnt);
        end
    endtask

    task automatic test_random();
        int    len;
        bit    wv, yum, acc;
        bit    done;
        done = 1'b0;
        for (int cyc = 0; cyc < 1600 && !done; cyc++) begin
            if (stream.size() == 0 && cyc < 800) begin
                len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(16, 24)) : int'($urandom_range(0, 6));
                stream.push_back(mk_hdr(len));
                for (int k = 0; k < len; k++) stream.push_back(mk_body());
            end
            n_checks++; if (wr_rdy !== (mq.size() < int'(DEPTH))) begin
                n_fail++; $display("FAIL rnd_wr_rdy@%0d: got %b want %b", cyc, wr_rdy, mq.size() < int'(DEPTH));
            end
            n_checks++; if (dout_val !== m_val() || (m_val() && dout_msg !== mq[0])) begin
                n_fail++; $display("FAIL rnd_out@%0d: val %b msg %h want %b", cyc, dout_val, dout_msg, m_val());
            end
            n_checks++; if (pkt_cnt !== 16'(pkts_sent) || busy !== m_busy() || err_oversize !== ovs_seen) begin
                n_fail++; $display("FAIL rnd_status@%0d: cnt %0d busy %b err %b want %0d %b %b",
                                   cyc, pkt_cnt, busy, err_oversize, pkts_sent, m_busy(), ovs_seen);
            end
            wv  = (stream.size() > 0) && ((cyc >= 800) || ($urandom_range(0, 3) != 0));
            yum = (cyc >= 800) || ($urandom_range(0, 3) != 0);
            acc = wv && (mq.size() < int'(DEPTH));
            step(wv, (stream.size() > 0) ? stream[0] : '0, yum);
            if (acc) void'(stream.pop_front());
            done = (cyc >= 800) && (stream.size() == 0) && !m_busy();
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL rnd_drain_timeout: queue %0d left", mq.size()); end
    endtask

    task automatic test_reset_mid();
        flit_t h, bf;
        step(1'b1, mk_hdr(2), 1'b0);
        step(1'b1, mk_body(), 1'b0);
        step(1'b1, mk_body(), 1'b0);
        step(1'b1, mk_hdr(4), 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (wr_rdy !== 1'b1 || dout_val !== 1'b0 || dout_msg !== 64'h0) begin
            n_fail++; $display("FAIL rstmid_out: rdy %b val %b msg %h want 1 0 0", wr_rdy, dout_val, dout_msg);
        end
        n_checks++; if (pkt_cnt !== 16'h0 || err_oversize !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_status: cnt %0d err %b busy %b want 0 0 0", pkt_cnt, err_oversize, busy);
        end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        h = mk_hdr(1); bf = mk_body();
        step(1'b1, h, 1'b1);
        step(1'b1, bf, 1'b1);
        n_checks++; if (dout_val !== 1'b1 || dout_msg !== h) begin
            n_fail++; $display("FAIL rstmid_new_head: val %b msg %h want 1 %h", dout_val, dout_msg, h);
        end
        step(1'b0, '0, 1'b1);
        n_checks++; if (dout_val !== 1'b1 || dout_msg !== bf) begin
            n_fail++; $display("FAIL rstmid_new_body: val %b msg %h want 1 %h", dout_val, dout_msg, bf);
        end
        step(1'b0, '0, 1'b1);
        n_checks++; if (dout_val !== 1'b0 || pkt_cnt !== 16'd1) begin
            n_fail++; $display("FAIL rstmid_end: val %b cnt %0d want 0 1", dout_val, pkt_cnt);
        end
    endtask

    initial begin
        wr_val   = 1'b0;
        wr_data  = '0;
        dout_yum = 1'b0;
        rst_n    = 1'b0;
        m_reset();
        test_reset();
        test_basic();
        test_stall();
        test_full();
        test_oversize();
        test_simul();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_flit_injector.md
# noc_flit_injector

Buffered transmitter for a 64-bit val/yum NoC link. It is the source end of the link that our pass-through tracing taps observe. Software or a test harness writes flits in through a simple valid/ready port. The block parses OpenPiton headers to find packet boundaries and launches each packet only once it is fully buffered, so downstream never sees a mid-packet bubble. Packets too large for the buffer are the one exception: they are cut through. It sits in front of any router input port or tracing tap.

## Interface
- `ID`, default "inj", instance tag used in trace prints
- `DEPTH`, default 16, FIFO depth in flits; power of two, ≥ 4
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `wr_val` in 1: write flit valid
- `wr_data` in 64: flit to enqueue
- `wr_rdy` out 1: FIFO not full; a flit is accepted when `wr_val & wr_rdy`
- `dout_msg` out 64: flit at FIFO head
- `dout_val` out 1: `dout_msg` valid
- `dout_yum` in 1: downstream consumes the flit; transfer occurs when `dout_val & dout_yum`
- `pkt_cnt` out 16: packets fully transmitted; wraps at 2^16
- `err_oversize` out 1: sticky; a header with payload length > DEPTH-1 was written
- `busy` out 1: FIFO non-empty or a packet is partially sent

## Operation
- Header flit: payload length is `[29:22]`, 0–255 body flits.
- **Write FSM**
  - States: W_HEAD, W_BODY.
  - An accepted flit in W_HEAD is a header.
    - len = 0: the packet is complete on this write.
    - len > 0: load `wr_rem` = len and go to W_BODY.
  - Each accepted body flit decrements `wr_rem`. The write that takes `wr_rem` from 1 to 0 completes the packet and returns the FSM to W_HEAD.
  - A packet completion increments `cmpl_cnt`, which is $clog2(DEPTH)+1 bits wide.
- **Oversize**
  - A header with len > DEPTH-1 sets `err_oversize`. It stays set until reset.
  - The same header also sets `ct_pending`, which permits cut-through for that packet.
  - Completion of an oversize packet does not increment `cmpl_cnt`.
- **Read FSM**
  - States: R_HEAD, R_BODY.
  - In R_HEAD, `dout_val` = FIFO non-empty & (`cmpl_cnt` > 0 | `ct_pending`).
  - In R_BODY, `dout_val` = FIFO non-empty.
  - On a header transfer:
    - If `ct_pending` is set and `cmpl_cnt` = 0, clear `ct_pending`; that packet is the cut-through packet.
    - If len > 0, load `rd_rem` = len and go to R_BODY.
  - On the last flit transfer of a normal packet, decrement `cmpl_cnt`. The last flit is the header when len = 0, or the body flit that takes `rd_rem` to 0.
  - On every packet's last flit transfer, increment `pkt_cnt`.
- **Simultaneous events**
  - An increment and a decrement of `cmpl_cnt` in the same cycle leave it unchanged.
  - A write and a read in the same cycle while full is impossible, since `wr_rdy` = 0.
  - A write and a read in the same cycle while empty: the written flit is not presented until the next cycle.
- FIFO pointers are $clog2(DEPTH)+1 bits with a wrap bit.
  - Full: addresses equal and wrap bits differ.
  - Empty: pointers equal.
- `dout_yum` while `dout_val` = 0 is ignored.

## Timing
- Reset values:
  - `wr_rdy` = 1, `dout_val` = 0, `dout_msg` = 0.
  - `pkt_cnt` = 0, `err_oversize` = 0, `busy` = 0.
  - Both FSMs in *_HEAD; `cmpl_cnt`, `ct_pending`, pointers cleared.
- Assertion of `rst_n` mid-packet discards all buffered flits immediately. No partial packet resumes.
- Latency: the write that completes a packet at edge N gives `dout_val` = 1 during cycle N+1.
- Throughput: one flit per cycle on each side when not blocked.
- `dout_msg` comes from the registered FIFO array at the read pointer and is stable while `dout_val & !dout_yum`.
- `wr_rdy` is combinational from the pointers only and is independent of `wr_val`.

## Configuration
- `NOC_FLIT_INJECTOR_TRACE_EN` defined: on every transfer, `$display("(%s): INJ flit %h", ID, dout_msg)`; on `err_oversize` rising, print a warning.
- Undefined: no simulation output. Logic is identical.

## Structure
- Shared package `noc_pkg`:
  - Header field offsets (`LEN_HI` = 29, `LEN_LO` = 22).
  - `flit_t` (64-bit).
  - FSM state enums.
- Sub-module `noc_flit_fifo`, parameter DEPTH: synchronous single-clock FIFO with `full`/`empty`, registered array.

## Test plan
- Write one len=2 header plus 2 body flits back to back, `dout_yum` = 1 → `dout_val` first high the cycle after the 3rd write; 3 consecutive transfers; `pkt_cnt` = 1.
- Write a len=3 header and 2 body flits, stall 5 cycles, then write the last body flit → `dout_val` = 0 throughout the stall; 4 flits sent with no bubble.
- Write 16 len=0 headers with `dout_yum` = 0 and DEPTH = 16 → `wr_rdy` = 0 after the 16th; asserting `dout_yum` drains 16 flits; `pkt_cnt` = 16.
- Write a len=20 header (DEPTH = 16) → `err_oversize` = 1; header sent before its body completes; all 21 flits delivered in order; `pkt_cnt` = 1.
- Complete packet A while packet B's last flit is written in the same cycle A's last flit transfers → `cmpl_cnt` unchanged; B launches next.
- Drop `rst_n` mid-packet → all outputs at reset values asynchronously; a new packet after release sends normally.
